// File: rtl/clockbox_pkg.sv
// Shared types and constants for the clockbox front-panel controller.
package clockbox_pkg;

  typedef enum logic [2:0] {
    OFF         = 3'd0,
    TIME        = 3'd1,
    CHRONO_IDLE = 3'd2,
    CHRONO_RUN  = 3'd3,
    CHRONO_STOP = 3'd4
  } state_t;

  localparam logic DISP_TIME   = 1'b0;
  localparam logic DISP_CHRONO = 1'b1;

  function automatic logic is_chrono(input state_t s);
    return (s == CHRONO_IDLE) || (s == CHRONO_RUN) || (s == CHRONO_STOP);
  endfunction

endpackage

// File: rtl/clockbox_mode_ctrl_btn_debounce.sv
// One front-panel button: 2-flop synchroniser, debounce counter, registered
// rising-edge press pulse. Presses are suppressed until the button is seen released.
module btn_debounce
  import clockbox_pkg::*;
#(
  parameter int DEB_CYCLES = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_prev;
  logic          r_press;
  logic          r_armed;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_arm_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_prev    <= 1'b0;
      r_press   <= 1'b0;
      r_armed   <= 1'b0;
      r_cnt     <= '0;
      r_arm_cnt <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;

      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end

      // A button held through reset must be seen low for a full debounce
      // window before its next rising edge counts as a press.
      if (!r_armed) begin
        if (r_sync2) begin
          r_arm_cnt <= '0;
        end else if (r_arm_cnt == CW'(DEB_CYCLES - 1)) begin
          r_armed <= 1'b1;
        end else begin
          r_arm_cnt <= r_arm_cnt + CW'(1);
        end
      end

      r_prev  <= r_level;
      r_press <= r_armed & r_level & ~r_prev;
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/clockbox_mode_ctrl.sv
// Clockbox front-panel controller: debounced buttons, mode-hold timer and the
// top-level mode FSM driving display and chronometer control lines.
module clockbox_mode_ctrl
  import clockbox_pkg::*;
#(
  parameter int DEB_CYCLES  = 100,
  parameter int HOLD_CYCLES = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       power_btn,
  input  logic       start_btn,
  input  logic       stop_btn,
  output logic       disp_on,
  output logic       disp_sel,
  output logic       chrono_en,
  output logic       chrono_clr,
  output logic [2:0] state_dbg
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic w_mode_lvl,  w_mode_press;
  logic w_power_lvl, w_power_press;
  logic w_start_lvl, w_start_press;
  logic w_stop_lvl,  w_stop_press;
  logic w_unused_lvl;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
    .clock(clock), .reset(reset), .i_btn(mode_btn),
    .o_level(w_mode_lvl), .o_press(w_mode_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_power (
    .clock(clock), .reset(reset), .i_btn(power_btn),
    .o_level(w_power_lvl), .o_press(w_power_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .clock(clock), .reset(reset), .i_btn(start_btn),
    .o_level(w_start_lvl), .o_press(w_start_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_stop (
    .clock(clock), .reset(reset), .i_btn(stop_btn),
    .o_level(w_stop_lvl), .o_press(w_stop_press)
  );

  assign w_unused_lvl = w_power_lvl ^ w_start_lvl ^ w_stop_lvl;

  // Mode-hold timer: counts from the press, saturates, fires once per press.
  logic          r_hold_active;
  logic          r_hold_fired;
  logic [HW-1:0] r_hold_cnt;
  logic          w_mode_hold;
  logic          w_mode_rel;
  logic          w_short_rel;

  assign w_mode_hold = r_hold_active & ~r_hold_fired & (r_hold_cnt == HW'(HOLD_CYCLES));
  assign w_mode_rel  = r_hold_active & ~w_mode_lvl;
  assign w_short_rel = w_mode_rel & (r_hold_cnt < HW'(HOLD_CYCLES));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hold_active <= 1'b0;
      r_hold_fired  <= 1'b0;
      r_hold_cnt    <= '0;
    end else if (w_mode_press) begin
      r_hold_active <= 1'b1;
      r_hold_fired  <= 1'b0;
      r_hold_cnt    <= HW'(1);
    end else if (w_mode_rel) begin
      r_hold_active <= 1'b0;
      r_hold_fired  <= 1'b0;
      r_hold_cnt    <= '0;
    end else if (r_hold_active) begin
      if (r_hold_cnt != HW'(HOLD_CYCLES)) begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end
      if (w_mode_hold) begin
        r_hold_fired <= 1'b1;
      end
    end
  end

  state_t r_state;
  state_t w_next;
  logic   w_clr_next;
  logic   r_disp_on;
  logic   r_disp_sel;
  logic   r_chrono_en;
  logic   r_chrono_clr;

  // Priority: power > mode_hold > stop > start; short mode release only matters in STOP.
  always_comb begin
    w_next     = r_state;
    w_clr_next = 1'b0;
    if (w_power_press) begin
      if (r_state == OFF) begin
        w_next = TIME;
      end else begin
        w_next     = OFF;
        w_clr_next = 1'b1;
      end
    end else if (r_state != OFF) begin
      if (w_mode_hold) begin
        w_next = (r_state == TIME) ? CHRONO_IDLE : TIME;
      end else begin
        case (r_state)
          CHRONO_IDLE: begin
            if (w_start_press && !w_stop_press) w_next = CHRONO_RUN;
          end
          CHRONO_RUN: begin
            if (w_stop_press) w_next = CHRONO_STOP;
          end
          CHRONO_STOP: begin
            if (w_short_rel) begin
              w_next     = CHRONO_IDLE;
              w_clr_next = 1'b1;
            end else if (w_start_press && !w_stop_press) begin
              w_next = CHRONO_RUN;
            end
          end
          default: begin
            w_next = r_state;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= TIME;
      r_disp_on    <= 1'b1;
      r_disp_sel   <= DISP_TIME;
      r_chrono_en  <= 1'b0;
      r_chrono_clr <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_disp_on    <= (w_next != OFF);
      r_disp_sel   <= is_chrono(w_next) ? DISP_CHRONO : DISP_TIME;
      r_chrono_en  <= (w_next == CHRONO_RUN);
      r_chrono_clr <= w_clr_next;
    end
  end

  assign disp_on    = r_disp_on;
  assign disp_sel   = r_disp_sel;
  assign chrono_en  = r_chrono_en;
  assign chrono_clr = r_chrono_clr;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_clockbox_mode_ctrl.sv
// Directed bench for clockbox_mode_ctrl with DEB_CYCLES=100, HOLD_CYCLES=20000.
module tb_clockbox_mode_ctrl;

  localparam int DEB  = 100;
  localparam int HOLD = 20000;

  // Expected {state_dbg, disp_on, disp_sel, chrono_en}
  localparam logic [5:0] O_OFF  = {3'd0, 3'b000};
  localparam logic [5:0] O_TIME = {3'd1, 3'b100};
  localparam logic [5:0] O_IDLE = {3'd2, 3'b110};
  localparam logic [5:0] O_RUN  = {3'd3, 3'b111};
  localparam logic [5:0] O_STOP = {3'd4, 3'b110};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mode_btn = 1'b0;
  logic       power_btn = 1'b0;
  logic       start_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       disp_on;
  logic       disp_sel;
  logic       chrono_en;
  logic       chrono_clr;
  logic [2:0] state_dbg;

  int total = 0;
  int bad = 0;
  int clr_seen = 0;
  int c0;

  clockbox_mode_ctrl #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clock(clock), .reset(reset),
    .mode_btn(mode_btn), .power_btn(power_btn),
    .start_btn(start_btn), .stop_btn(stop_btn),
    .disp_on(disp_on), .disp_sel(disp_sel), .chrono_en(chrono_en),
    .chrono_clr(chrono_clr), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;

  always @(negedge clock) if (chrono_clr === 1'b1) clr_seen++;

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] outs();
    return {state_dbg, disp_on, disp_sel, chrono_en};
  endfunction

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_btn(input int which, input logic v);
    case (which)
      0: mode_btn  = v;
      1: power_btn = v;
      2: start_btn = v;
      default: stop_btn = v;
    endcase
  endtask

  task automatic pulse_btn(input int which, input int len);
    drive_btn(which, 1'b1);
    step(len);
    drive_btn(which, 1'b0);
    step(DEB + 150);
  endtask

  task automatic test_reset();
    step(3);
    total++; if (outs() !== O_TIME) begin bad++; $display("FAIL reset_outs: got %b want %b", outs(), O_TIME); end
    total++; if (chrono_clr !== 1'b0) begin bad++; $display("FAIL reset_clr: got %b want 0", chrono_clr); end
    reset = 1'b1;
    step(200);
    total++; if (outs() !== O_TIME) begin bad++; $display("FAIL idle_after_reset: got %b want %b", outs(), O_TIME); end
  endtask

  task automatic test_mode_hold();
    c0 = clr_seen;
    mode_btn = 1'b1;
    step(HOLD + 103);
    total++; if (outs() !== O_TIME) begin bad++; $display("FAIL hold_early: got %b want %b", outs(), O_TIME); end
    step(1);
    total++; if (outs() !== O_IDLE) begin bad++; $display("FAIL hold_enter: got %b want %b", outs(), O_IDLE); end
    step(22000 - (HOLD + 104));
    total++; if (outs() !== O_IDLE) begin bad++; $display("FAIL hold_oneshot: got %b want %b", outs(), O_IDLE); end
    mode_btn = 1'b0;
    step(250);
    total++; if (outs() !== O_IDLE) begin bad++; $display("FAIL hold_release: got %b want %b", outs(), O_IDLE); end
    total++; if (clr_seen !== c0) begin bad++; $display("FAIL hold_noclr: got %0d want %0d", clr_seen, c0); end
  endtask

  task automatic test_start_stop();
    start_btn = 1'b1; stop_btn = 1'b1;
    step(150);
    start_btn = 1'b0; stop_btn = 1'b0;
    step(250);
    total++; if (outs() !== O_IDLE) begin bad++; $display("FAIL idle_both: got %b want %b", outs(), O_IDLE); end
    start_btn = 1'b1;
    step(103);
    total++; if (outs() !== O_IDLE) begin bad++; $display("FAIL start_early: got %b want %b", outs(), O_IDLE); end
    step(1);
    total++; if (outs() !== O_RUN) begin bad++; $display("FAIL start_run: got %b want %b", outs(), O_RUN); end
    step(46);
    start_btn = 1'b0;
    step(2000);
    stop_btn = 1'b1;
    step(104);
    total++; if (outs() !== O_STOP) begin bad++; $display("FAIL stop: got %b want %b", outs(), O_STOP); end
    stop_btn = 1'b0;
    step(250);
  endtask

  task automatic test_short_clear();
    c0 = clr_seen;
    mode_btn = 1'b1;
    step(500);
    total++; if (outs() !== O_STOP) begin bad++; $display("FAIL short_held: got %b want %b", outs(), O_STOP); end
    mode_btn = 1'b0;
    step(102);
    total++; if (outs() !== O_STOP || clr_seen !== c0) begin bad++; $display("FAIL short_early: got %b/%0d want %b/%0d", outs(), clr_seen, O_STOP, c0); end
    step(1);
    total++; if (outs() !== O_IDLE || chrono_clr !== 1'b1) begin bad++; $display("FAIL short_clear: got %b clr=%b want %b clr=1", outs(), chrono_clr, O_IDLE); end
    step(1);
    total++; if (chrono_clr !== 1'b0 || clr_seen !== c0 + 1) begin bad++; $display("FAIL clr_width: got clr=%b n=%0d want clr=0 n=%0d", chrono_clr, clr_seen, c0 + 1); end
    step(100);
  endtask

  task automatic test_back_to_back();
    pulse_btn(2, 150);
    total++; if (outs() !== O_RUN) begin bad++; $display("FAIL b2b_run: got %b want %b", outs(), O_RUN); end
    start_btn = 1'b1; stop_btn = 1'b1;
    step(104);
    total++; if (outs() !== O_STOP) begin bad++; $display("FAIL b2b_stop_wins: got %b want %b", outs(), O_STOP); end
    start_btn = 1'b0; stop_btn = 1'b0;
    step(250);
    total++; if (outs() !== O_STOP) begin bad++; $display("FAIL b2b_settle: got %b want %b", outs(), O_STOP); end
  endtask

  task automatic test_bounce();
    c0 = clr_seen;
    for (int i = 0; i < 20; i++) begin
      mode_btn = ~mode_btn;
      step(50);
    end
    step(300);
    total++; if (outs() !== O_STOP || clr_seen !== c0) begin bad++; $display("FAIL bounce: got %b/%0d want %b/%0d", outs(), clr_seen, O_STOP, c0); end
  endtask

  task automatic test_hold_no_clear();
    c0 = clr_seen;
    mode_btn = 1'b1;
    step(HOLD + 104);
    total++; if (outs() !== O_TIME) begin bad++; $display("FAIL stop_hold_time: got %b want %b", outs(), O_TIME); end
    total++; if (clr_seen !== c0) begin bad++; $display("FAIL stop_hold_noclr: got %0d want %0d", clr_seen, c0); end
    mode_btn = 1'b0;
    step(250);
    pulse_btn(2, 150);
    total++; if (outs() !== O_TIME) begin bad++; $display("FAIL start_in_time: got %b want %b", outs(), O_TIME); end
  endtask

  task automatic test_power();
    mode_btn = 1'b1;
    step(HOLD + 104);
    mode_btn = 1'b0;
    step(250);
    total++; if (outs() !== O_IDLE) begin bad++; $display("FAIL pwr_setup: got %b want %b", outs(), O_IDLE); end
    pulse_btn(2, 150);
    c0 = clr_seen;
    power_btn = 1'b1;
    step(103);
    total++; if (outs() !== O_RUN) begin bad++; $display("FAIL pwr_early: got %b want %b", outs(), O_RUN); end
    step(1);
    total++; if (outs() !== O_OFF || chrono_clr !== 1'b1) begin bad++; $display("FAIL pwr_off: got %b clr=%b want %b clr=1", outs(), chrono_clr, O_OFF); end
    power_btn = 1'b0;
    step(250);
    total++; if (clr_seen !== c0 + 1) begin bad++; $display("FAIL pwr_clr_count: got %0d want %0d", clr_seen, c0 + 1); end
    pulse_btn(2, 150);
    total++; if (outs() !== O_OFF) begin bad++; $display("FAIL start_in_off: got %b want %b", outs(), O_OFF); end
    pulse_btn(1, 150);
    total++; if (outs() !== O_TIME) begin bad++; $display("FAIL pwr_on: got %b want %b", outs(), O_TIME); end
  endtask

  task automatic test_reset_mid();
    pulse_btn(1, 150);
    total++; if (outs() !== O_OFF) begin bad++; $display("FAIL rst_setup: got %b want %b", outs(), O_OFF); end
    power_btn = 1'b1;
    step(60);
    #2 reset = 1'b0;
    #1;
    total++; if (outs() !== O_TIME || chrono_clr !== 1'b0) begin bad++; $display("FAIL rst_async: got %b clr=%b want %b clr=0", outs(), chrono_clr, O_TIME); end
    @(negedge clock);
    reset = 1'b1;
    step(300);
    total++; if (outs() !== O_TIME) begin bad++; $display("FAIL rst_held_btn: got %b want %b", outs(), O_TIME); end
    power_btn = 1'b0;
    step(250);
    pulse_btn(1, 150);
    total++; if (outs() !== O_OFF) begin bad++; $display("FAIL rst_repress: got %b want %b", outs(), O_OFF); end
  endtask

  initial begin
    test_reset();
    test_mode_hold();
    test_start_stop();
    test_short_clear();
    test_back_to_back();
    test_bounce();
    test_hold_no_clear();
    test_power();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clockbox_mode_ctrl.md
# clockbox_mode_ctrl

Front-panel controller for the clockbox. Conditions the four raw buttons (mode, power, start, stop), runs the top-level mode FSM, and drives the control lines that sequence the time-of-day counter, the chronometer counter and the LED-matrix scanner. It sits between the `io_in[3:0]` pins and the counter/display datapath, and issues every enable, clear and select those blocks consume.

## Interface
- `DEB_CYCLES`, 100: consecutive stable cycles (after synchronisation) required to accept a button level (10 ms at 10 kHz).
- `HOLD_CYCLES`, 20000: debounced mode-button hold length that switches between TIME and CHRONO (2 s at 10 kHz).
- `clock`  in  1: system clock, 10 kHz nominal.
- `reset`  in  1: asynchronous, active-low reset.
- `mode_btn`  in  1: raw mode button, asynchronous, active-high.
- `power_btn`  in  1: raw power button, asynchronous, active-high.
- `start_btn`  in  1: raw chronometer start, asynchronous, active-high.
- `stop_btn`  in  1: raw chronometer stop, asynchronous, active-high.
- `disp_on`  out  1: display scanner enable; 0 blanks all rows.
- `disp_sel`  out  1: display source select, 0 = time, 1 = chrono.
- `chrono_en`  out  1: chronometer count enable.
- `chrono_clr`  out  1: one-cycle synchronous clear pulse for the chronometer.
- `state_dbg`  out  3: current FSM state encoding.

## Operation
- Each button passes through a 2-flop synchroniser, then a debounce counter. The debounced level flips only after the synchronised level has differed from it for `DEB_CYCLES` consecutive cycles. Any bounce restarts the count.
- A rising edge of a debounced level produces a 1-cycle `*_press` pulse.
- FSM states: OFF, TIME, CHRONO_IDLE, CHRONO_RUN, CHRONO_STOP.
- **Power.** `power_press` in any on-state goes to OFF and pulses `chrono_clr`. `power_press` in OFF goes to TIME.
- **Mode hold.** The hold counter starts on `mode_press`, clears on debounced release, and saturates at `HOLD_CYCLES`. When it reaches `HOLD_CYCLES`, a one-shot `mode_hold` fires once per press, even if the button stays held.
    - TIME + `mode_hold` goes to CHRONO_IDLE.
    - Any CHRONO_* + `mode_hold` goes to TIME and leaves `chrono_en` at 0. The chrono value is retained, with no clear.
- **Start.** `start_press` moves CHRONO_IDLE or CHRONO_STOP to CHRONO_RUN.
- **Stop.** `stop_press` moves CHRONO_RUN to CHRONO_STOP.
- **Clear.** A mode release shorter than `HOLD_CYCLES` while in CHRONO_STOP pulses `chrono_clr` and goes to CHRONO_IDLE. Short mode presses are ignored in every other state.
- **Ignored presses.** Start, stop and mode are ignored in OFF. Start and stop are ignored in TIME.
- **Priority within one cycle:** power > mode_hold > stop > start. A simultaneous start and stop in CHRONO_IDLE stays in IDLE. In CHRONO_RUN it goes to STOP.
- **Outputs are registered and decoded from the state:**
    - `disp_on` = 1 except in OFF.
    - `disp_sel` = 1 in CHRONO_*.
    - `chrono_en` = 1 only in CHRONO_RUN.

## Timing
- **Reset values:** state TIME, `disp_on`=1, `disp_sel`=0, `chrono_en`=0, `chrono_clr`=0, `state_dbg`=TIME. Synchronisers, debounced levels and all counters are 0.
- Reset asserted mid-operation clears everything immediately and asynchronously. Buttons still held at reset release do not fire presses until they are released and pressed again.
- **Press latency:** the raw edge is sampled at edge 0 and the press pulse is high after edge `DEB_CYCLES`+2. The FSM state and outputs change at edge `DEB_CYCLES`+3.
- **Hold latency:** `mode_hold` fires exactly `HOLD_CYCLES` cycles after `mode_press`. The state changes on the following edge.
- **Clear timing:** `chrono_clr` is high for exactly one cycle, coincident with the transition edge.

## Structure
- `clockbox_pkg` holds:
    - the `state_t` enum: OFF=0, TIME=1, CHRONO_IDLE=2, CHRONO_RUN=3, CHRONO_STOP=4;
    - the `DISP_TIME` and `DISP_CHRONO` constants.
- Sub-module `btn_debounce` (parameter `DEB_CYCLES`; outputs level and press pulse), instantiated four times.
- The hold counter and FSM live in `clockbox_mode_ctrl`.

## Test plan
All scenarios use `DEB_CYCLES`=100 and `HOLD_CYCLES`=20000.
1. Release reset with all buttons low -> TIME, `disp_on`=1, `disp_sel`=0, `chrono_en`=0 until the first press.
2. Hold mode for 20000 cycles, then release -> CHRONO_IDLE exactly 20103 edges after the raw edge. Continuing to hold to 60000 cycles causes no further transition.
3. In CHRONO_IDLE, press start -> `chrono_en`=1 at edge 103. Press stop 30000 cycles later -> `chrono_en`=0, state CHRONO_STOP.
4. In CHRONO_STOP, press mode for 500 cycles -> one `chrono_clr` pulse and CHRONO_IDLE. Hold mode 20000 cycles instead -> TIME with no clear.
5. Toggle mode every 50 cycles for 1000 cycles, then release -> no press detected and state unchanged. Assert start and stop together in CHRONO_RUN -> CHRONO_STOP.
6. Press power in CHRONO_RUN -> OFF, `disp_on`=0, `chrono_clr` pulse. Press power again -> TIME. Pull reset low mid-debounce -> all outputs at reset values within the same cycle.
